lloyds_iter_sequencer: RTL and testbench

LLOYDS_ITER_SEQUENCER -- requirements
Module: lloyds_iter_sequencer

---
 rtl/lloyds_iter_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_lloyds_iter_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lloyds_iter_sequencer.sv
// Sequencer for a three-kernel Lloyd's (k-means) iteration: init kernel once, then
// block-wise assignment passes and a distortion pass per iteration until convergence.
module lloyds_iter_sequencer #(
    parameter int N       = 128,
    parameter int K       = 4,
    parameter int D       = 3,
    parameter int B       = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk_in1,
    input  logic        reset_n,
    input  logic        go,
    input  logic        abort,
    input  logic [7:0]  max_iter,
    input  logic [31:0] threshold,
    output logic [2:0]  ap_start,
    input  logic [2:0]  ap_ready,
    input  logic [2:0]  ap_done,
    output logic [31:0] n_V,
    output logic [7:0]  k_V,
    output logic [31:0] block_address,
    input  logic [31:0] distortion_out,
    input  logic        distortion_out_ap_vld,
    output logic        busy,
    output logic        done,
    output logic        converged,
    output logic        error,
    output logic [7:0]  iter_count,
    output logic [31:0] last_distortion
);

    typedef enum logic [3:0] {
        IDLE, START_1, RUN_1, START_2, RUN_2, NEXT_BLK,
        START_3, RUN_3, CHECK, FINISH, ERROR
    } state_t;

    localparam logic [31:0] LAST_BLK_ADDR = 32'((N - B) * D);
    localparam logic [31:0] BLK_STEP      = 32'(B * D);
    localparam logic [31:0] WD_LIMIT      = 32'(TIMEOUT - 1);

    state_t      state, next_state;
    logic [31:0] prev_dist;
    logic [31:0] watchdog;

    logic        clear_run, blk_reset, blk_advance, set_conv, bump_iter, save_prev;
    logic        latch_dist, in_kernel, entering_start;
    logic [7:0]  iter_inc, iter_limit;
    logic [31:0] abs_diff;

    assign n_V = 32'(N - 1);
    assign k_V = 8'(K - 1);

    assign ap_start = {state == START_3, state == START_2, state == START_1};
    assign busy     = (state != IDLE) && (state != ERROR);
    assign done     = (state == FINISH);
    assign error    = (state == ERROR);

    assign iter_inc   = (iter_count == 8'hFF) ? 8'hFF : iter_count + 8'd1;
    assign iter_limit = (max_iter == 8'd0) ? 8'd1 : max_iter;
    assign abs_diff   = (last_distortion >= prev_dist) ? (last_distortion - prev_dist)
                                                       : (prev_dist - last_distortion);

    assign in_kernel = (state == START_1) || (state == RUN_1) ||
                       (state == START_2) || (state == RUN_2) ||
                       (state == START_3) || (state == RUN_3);
    assign entering_start = (next_state != state) &&
                            ((next_state == START_1) || (next_state == START_2) ||
                             (next_state == START_3));

    always_ff @(posedge clk_in1 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // A kernel that reports ready and done together in its start cycle takes the run exit directly.
    always_comb begin
        next_state  = state;
        clear_run   = 1'b0;
        blk_reset   = 1'b0;
        blk_advance = 1'b0;
        set_conv    = 1'b0;
        bump_iter   = 1'b0;
        save_prev   = 1'b0;
        latch_dist  = 1'b0;
        case (state)
            IDLE, ERROR: begin
                if (go) begin
                    next_state = START_1;
                    clear_run  = 1'b1;
                end
            end
            START_1: begin
                if (ap_ready[0] && ap_done[0]) begin
                    next_state = START_2;
                    blk_reset  = 1'b1;
                end else if (ap_ready[0]) begin
                    next_state = RUN_1;
                end
            end
            RUN_1: begin
                if (ap_done[0]) begin
                    next_state = START_2;
                    blk_reset  = 1'b1;
                end
            end
            START_2: begin
                if (ap_ready[1]) next_state = ap_done[1] ? NEXT_BLK : RUN_2;
            end
            RUN_2: begin
                if (ap_done[1]) next_state = NEXT_BLK;
            end
            NEXT_BLK: begin
                if (block_address < LAST_BLK_ADDR) begin
                    next_state  = START_2;
                    blk_advance = 1'b1;
                end else begin
                    next_state = START_3;
                end
            end
            START_3: begin
                if (ap_ready[2] && ap_done[2]) begin
                    next_state = CHECK;
                    latch_dist = distortion_out_ap_vld;
                end else if (ap_ready[2]) begin
                    next_state = RUN_3;
                end
            end
            RUN_3: begin
                latch_dist = distortion_out_ap_vld;
                if (ap_done[2]) next_state = CHECK;
            end
            CHECK: begin
                bump_iter = 1'b1;
                if ((iter_count != 8'd0) && (abs_diff <= threshold)) begin
                    next_state = FINISH;
                    set_conv   = 1'b1;
                end else if (iter_inc >= iter_limit) begin
                    next_state = FINISH;
                end else begin
                    next_state = START_2;
                    save_prev  = 1'b1;
                    blk_reset  = 1'b1;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase

        if (in_kernel && (watchdog >= WD_LIMIT)) begin
            next_state  = ERROR;
            blk_reset   = 1'b0;
            blk_advance = 1'b0;
            latch_dist  = 1'b0;
        end

        // Abort wins over everything, including a kernel done in the same cycle.
        if (abort && (state != IDLE)) begin
            next_state  = IDLE;
            clear_run   = 1'b0;
            blk_reset   = 1'b0;
            blk_advance = 1'b0;
            set_conv    = 1'b0;
            bump_iter   = 1'b0;
            save_prev   = 1'b0;
            latch_dist  = 1'b0;
        end
    end

    always_ff @(posedge clk_in1 or negedge reset_n) begin
        if (!reset_n) begin
            block_address   <= 32'd0;
            iter_count      <= 8'd0;
            last_distortion <= 32'd0;
            prev_dist       <= 32'd0;
            watchdog        <= 32'd0;
            converged       <= 1'b0;
        end else begin
            if (clear_run) begin
                iter_count <= 8'd0;
                converged  <= 1'b0;
            end
            if (bump_iter)  iter_count <= iter_inc;
            if (set_conv)   converged  <= 1'b1;
            if (save_prev)  prev_dist  <= last_distortion;
            if (latch_dist) last_distortion <= distortion_out;
            if (blk_reset)        block_address <= 32'd0;
            else if (blk_advance) block_address <= block_address + BLK_STEP;
            if (entering_start)   watchdog <= 32'd0;
            else if (in_kernel)   watchdog <= watchdog + 32'd1;
        end
    end

endmodule

// File: tb/tb_lloyds_iter_sequencer.sv
// Directed bench for lloyds_iter_sequencer with a behavioural three-kernel responder.
module tb_lloyds_iter_sequencer;

    logic        clk_in1 = 1'b0;
    logic        reset_n;
    logic        go;
    logic        abort;
    logic [7:0]  max_iter;
    logic [31:0] threshold;
    logic [2:0]  ap_start;
    logic [2:0]  ap_ready;
    logic [2:0]  ap_done;
    logic [31:0] n_V;
    logic [7:0]  k_V;
    logic [31:0] block_address;
    logic [31:0] distortion_out;
    logic        distortion_out_ap_vld;
    logic        busy, done, converged, error;
    logic [7:0]  iter_count;
    logic [31:0] last_distortion;

    // Responder state (owned by the kernel model process)
    logic [2:0]  done_pulse;
    int          cnt [3];
    int          starts [3];
    int          k3_dones;
    logic [31:0] k2_addr [$];

    // Test configuration (owned by the main process)
    logic [2:0]  instant_done;
    logic [2:0]  hold_done;
    logic [31:0] dist_tab [8];
    int          dist_base;

    int vectors;
    int miscompares;

    assign ap_ready = ap_start;
    assign ap_done  = done_pulse | (ap_start & instant_done);

    always #5 clk_in1 = ~clk_in1;

    lloyds_iter_sequencer #(.TIMEOUT(64)) dut (
        .clk_in1(clk_in1), .reset_n(reset_n), .go(go), .abort(abort),
        .max_iter(max_iter), .threshold(threshold),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .n_V(n_V), .k_V(k_V), .block_address(block_address),
        .distortion_out(distortion_out), .distortion_out_ap_vld(distortion_out_ap_vld),
        .busy(busy), .done(done), .converged(converged), .error(error),
        .iter_count(iter_count), .last_distortion(last_distortion)
    );

    // Each accepted start raises done five cycles later; kernel 3 delivers the next table distortion.
    initial begin
        done_pulse = 3'b000;
        distortion_out = 32'd0;
        distortion_out_ap_vld = 1'b0;
        k3_dones = 0;
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            starts[i] = 0;
        end
        forever begin
            @(negedge clk_in1);
            done_pulse = 3'b000;
            distortion_out_ap_vld = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i] = cnt[i] - 1;
                    if (cnt[i] == 0 && !hold_done[i]) begin
                        done_pulse[i] = 1'b1;
                        if (i == 2) begin
                            distortion_out = dist_tab[(k3_dones - dist_base) & 7];
                            distortion_out_ap_vld = 1'b1;
                            k3_dones = k3_dones + 1;
                        end
                    end
                end
                if (ap_start[i] && ap_ready[i]) begin
                    starts[i] = starts[i] + 1;
                    if (i == 1) k2_addr.push_back(block_address);
                    if (!instant_done[i]) cnt[i] = 5;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk_in1);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] mi, input logic [31:0] th);
        max_iter  = mi;
        threshold = th;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            tick();
            if (done) seen = 1'b1;
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic waitK2Starts(input int base, input int n);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            tick();
            if (starts[1] - base >= n) seen = 1'b1;
        end
        checkOutput("k2_start_seen", 32'(seen), 32'd1);
    endtask

    task automatic quietWindow(input string tag, input int cycles);
        logic any_start;
        any_start = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (ap_start != 3'b000) any_start = 1'b1;
        end
        checkOutput(tag, 32'(any_start), 32'd0);
    endtask

    initial begin
        int b0, b1, b2, abase;
        logic seen;
        vectors = 0;
        miscompares = 0;
        reset_n = 1'b0;
        go = 1'b0;
        abort = 1'b0;
        max_iter = 8'd5;
        threshold = 32'd10;
        instant_done = 3'b000;
        hold_done = 3'b000;
        dist_base = 0;
        for (int i = 0; i < 8; i++) dist_tab[i] = 32'd0;

        $display("[TB] reset state");
        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_conv", 32'(converged), 32'd0);
        checkOutput("rst_iter", 32'(iter_count), 32'd0);
        checkOutput("rst_apstart", 32'(ap_start), 32'd0);
        checkOutput("rst_baddr", block_address, 32'd0);
        checkOutput("n_V", n_V, 32'd127);
        checkOutput("k_V", 32'(k_V), 32'd3);
        reset_n = 1'b1;
        tick();

        $display("[TB] convergence after two iterations");
        dist_tab[0] = 32'd1000;
        dist_tab[1] = 32'd992;
        dist_base = k3_dones;
        b0 = starts[0]; b1 = starts[1]; b2 = starts[2]; abase = k2_addr.size();
        applyStimulus(8'd5, 32'd10);
        checkOutput("busy_run", 32'(busy), 32'd1);
        waitDone(2000);
        checkOutput("conv_converged", 32'(converged), 32'd1);
        checkOutput("conv_iter", 32'(iter_count), 32'd2);
        checkOutput("conv_last", last_distortion, 32'd992);
        checkOutput("conv_k1_starts", 32'(starts[0] - b0), 32'd1);
        checkOutput("conv_k2_starts", 32'(starts[1] - b1), 32'd16);
        checkOutput("conv_k3_starts", 32'(starts[2] - b2), 32'd2);
        for (int j = 0; j < 16; j++)
            checkOutput($sformatf("k2_addr%0d", j), k2_addr[abase + j], 32'((j % 8) * 48));
        tick();
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("conv_hold", 32'(converged), 32'd1);

        $display("[TB] iteration limit reached");
        dist_tab[0] = 32'd1000;
        dist_tab[1] = 32'd800;
        dist_tab[2] = 32'd600;
        dist_base = k3_dones;
        b0 = starts[0]; b2 = starts[2];
        applyStimulus(8'd3, 32'd10);
        checkOutput("go_clears_conv", 32'(converged), 32'd0);
        waitDone(2000);
        checkOutput("lim_converged", 32'(converged), 32'd0);
        checkOutput("lim_iter", 32'(iter_count), 32'd3);
        checkOutput("lim_last", last_distortion, 32'd600);
        checkOutput("lim_k1_starts", 32'(starts[0] - b0), 32'd1);
        checkOutput("lim_k3_starts", 32'(starts[2] - b2), 32'd3);
        tick();

        $display("[TB] kernel 1 ready+done in one cycle, max_iter 0");
        instant_done = 3'b001;
        dist_tab[0] = 32'd500;
        dist_base = k3_dones;
        applyStimulus(8'd0, 32'd10);
        checkOutput("skip_start1", 32'(ap_start), 32'd1);
        tick();
        checkOutput("skip_start2", 32'(ap_start), 32'd2);
        instant_done = 3'b000;
        waitDone(2000);
        checkOutput("skip_iter", 32'(iter_count), 32'd1);
        checkOutput("skip_conv", 32'(converged), 32'd0);
        checkOutput("skip_last", last_distortion, 32'd500);
        tick();

        $display("[TB] watchdog timeout on kernel 2");
        hold_done = 3'b010;
        applyStimulus(8'd5, 32'd10);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (ap_start[1]) seen = 1'b1;
        end
        checkOutput("to_start2_seen", 32'(seen), 32'd1);
        for (int c = 0; c < 63; c++) tick();
        checkOutput("to_err_early", 32'(error), 32'd0);
        tick();
        checkOutput("to_error", 32'(error), 32'd1);
        checkOutput("to_busy", 32'(busy), 32'd0);
        checkOutput("to_apstart", 32'(ap_start), 32'd0);
        hold_done = 3'b000;
        tick();
        tick();
        checkOutput("to_err_hold", 32'(error), 32'd1);
        applyStimulus(8'd5, 32'd10);
        checkOutput("to_restart", 32'(ap_start), 32'd1);
        checkOutput("to_err_clear", 32'(error), 32'd0);

        $display("[TB] abort during 4th kernel 2 run");
        b1 = starts[1];
        waitK2Starts(b1, 4);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("ab_busy", 32'(busy), 32'd0);
        checkOutput("ab_apstart", 32'(ap_start), 32'd0);
        checkOutput("ab_error", 32'(error), 32'd0);
        quietWindow("ab_quiet", 20);

        $display("[TB] reset during 4th kernel 2 run");
        b1 = starts[1];
        applyStimulus(8'd5, 32'd10);
        waitK2Starts(b1, 4);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checkOutput("rr_busy", 32'(busy), 32'd0);
        checkOutput("rr_apstart", 32'(ap_start), 32'd0);
        checkOutput("rr_baddr", block_address, 32'd0);
        checkOutput("rr_iter", 32'(iter_count), 32'd0);
        checkOutput("rr_last", last_distortion, 32'd0);
        tick();
        reset_n = 1'b1;
        quietWindow("rr_quiet", 20);
        checkOutput("rr_idle_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
